router_fsm: RTL and testbench

Control state machine for the 1x3 router. It decodes the 2-bit destination address of each incoming packet and waits for the target output FIFO to drain. It then sequences the register block through header, payload, FIFO-full stall, parity load and parity check, using one-hot state strobes. It sits between the packet input, the three output FIFOs and the input register block, and drives the write-enable path into the FIFOs.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_fsm.sv | 141 ++++++++++++++
 tb/tb_router_fsm.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | router_pkg : shared types and defaults for the 1x3 router control  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package router_pkg;

   localparam int          ADDR_W_DEF    = 2;
   localparam int          NUM_PORTS_DEF = 3;
   localparam logic [1:0]  INVALID_ADDR  = 2'b11;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      WAIT_TILL_EMPTY    = 3'd1,
      LOAD_FIRST_DATA    = 3'd2,
      LOAD_DATA          = 3'd3,
      FIFO_FULL_STATE    = 3'd4,
      LOAD_AFTER_FULL    = 3'd5,
      LOAD_PARITY        = 3'd6,
      CHECK_PARITY_ERROR = 3'd7
   } state_t;

endpackage
`default_nettype wire

// File: rtl/router_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | router_fsm : packet control FSM, address decode and FIFO write path |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module router_fsm
   import router_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int NUM_PORTS = NUM_PORTS_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 packet_valid,
   input  logic [ADDR_W-1:0]    datain,
   input  logic                 fifo_full,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic [NUM_PORTS-1:0] soft_reset,
   input  logic                 parity_done,
   input  logic                 low_packet_valid,
   output logic                 detect_add,
   output logic                 lfd_state,
   output logic                 ld_state,
   output logic                 full_state,
   output logic                 laf_state,
   output logic                 rst_int_reg,
   output logic                 write_enb_reg,
   output logic                 busy
);

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               detect_add_q, lfd_state_q, ld_state_q, full_state_q;
   logic               laf_state_q, rst_int_reg_q, write_enb_reg_q, busy_q;
   logic               detect_add_d, lfd_state_d, ld_state_d, full_state_d;
   logic               laf_state_d, rst_int_reg_d, write_enb_reg_d, busy_d;
   logic               sel_soft, sel_empty, dec_ok, dec_empty;

   // Port selection by loop so out-of-range addresses simply select nothing
   always_comb begin
      sel_soft  = 1'b0;
      sel_empty = 1'b0;
      dec_ok    = 1'b0;
      dec_empty = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (addr_q == ADDR_W'(i)) begin
            sel_soft  = soft_reset[i];
            sel_empty = fifo_empty[i];
         end
         if (datain == ADDR_W'(i)) begin
            dec_ok    = 1'b1;
            dec_empty = fifo_empty[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      if (state_q == DECODE_ADDRESS && packet_valid)
         addr_d = datain;
      if (state_q != DECODE_ADDRESS && sel_soft) begin
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS:
               if (packet_valid && dec_ok)
                  state_d = dec_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            WAIT_TILL_EMPTY:
               if (sel_empty) state_d = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:
               state_d = LOAD_DATA;
            LOAD_DATA:
               if (fifo_full)          state_d = FIFO_FULL_STATE;
               else if (!packet_valid) state_d = LOAD_PARITY;
            FIFO_FULL_STATE:
               if (!fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
               if (parity_done)           state_d = DECODE_ADDRESS;
               else if (low_packet_valid) state_d = LOAD_PARITY;
               else                       state_d = LOAD_DATA;
            LOAD_PARITY:
               state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
               state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:
               state_d = DECODE_ADDRESS;
         endcase
      end
   end

   // Strobes decoded from the next state and registered, so they track state_q exactly
   always_comb begin
      detect_add_d    = (state_d == DECODE_ADDRESS);
      lfd_state_d     = (state_d == LOAD_FIRST_DATA);
      ld_state_d      = (state_d == LOAD_DATA);
      full_state_d    = (state_d == FIFO_FULL_STATE);
      laf_state_d     = (state_d == LOAD_AFTER_FULL);
      rst_int_reg_d   = (state_d == CHECK_PARITY_ERROR);
      write_enb_reg_d = (state_d == LOAD_DATA) || (state_d == LOAD_PARITY) ||
                        (state_d == LOAD_AFTER_FULL);
      busy_d          = !((state_d == DECODE_ADDRESS) || (state_d == LOAD_DATA));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= DECODE_ADDRESS;
         addr_q          <= '0;
         detect_add_q    <= 1'b1;
         lfd_state_q     <= 1'b0;
         ld_state_q      <= 1'b0;
         full_state_q    <= 1'b0;
         laf_state_q     <= 1'b0;
         rst_int_reg_q   <= 1'b0;
         write_enb_reg_q <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         detect_add_q    <= detect_add_d;
         lfd_state_q     <= lfd_state_d;
         ld_state_q      <= ld_state_d;
         full_state_q    <= full_state_d;
         laf_state_q     <= laf_state_d;
         rst_int_reg_q   <= rst_int_reg_d;
         write_enb_reg_q <= write_enb_reg_d;
         busy_q          <= busy_d;
      end
   end

   assign detect_add    = detect_add_q;
   assign lfd_state     = lfd_state_q;
   assign ld_state      = ld_state_q;
   assign full_state    = full_state_q;
   assign laf_state     = laf_state_q;
   assign rst_int_reg   = rst_int_reg_q;
   assign write_enb_reg = write_enb_reg_q;
   assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_router_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_router_fsm : directed self-checking bench for router_fsm         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_router_fsm;

   // Output vector {detect_add,lfd,ld,full,laf,rst_int,write_enb,busy}
   localparam logic [7:0] C_DEC  = 8'h80;
   localparam logic [7:0] C_WAIT = 8'h01;
   localparam logic [7:0] C_LFD  = 8'h41;
   localparam logic [7:0] C_LD   = 8'h22;
   localparam logic [7:0] C_FULL = 8'h11;
   localparam logic [7:0] C_LAF  = 8'h0B;
   localparam logic [7:0] C_LP   = 8'h03;
   localparam logic [7:0] C_CHK  = 8'h05;

   logic       clk = 1'b0;
   logic       reset, packet_valid, fifo_full, parity_done, low_packet_valid;
   logic [1:0] datain;
   logic [2:0] fifo_empty, soft_reset;
   logic       detect_add, lfd_state, ld_state, full_state, laf_state;
   logic       rst_int_reg, write_enb_reg, busy;
   logic [7:0] outs;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   router_fsm #(.ADDR_W(2), .NUM_PORTS(3)) dut (
      .clk              (clk),
      .reset            (reset),
      .packet_valid     (packet_valid),
      .datain           (datain),
      .fifo_full        (fifo_full),
      .fifo_empty       (fifo_empty),
      .soft_reset       (soft_reset),
      .parity_done      (parity_done),
      .low_packet_valid (low_packet_valid),
      .detect_add       (detect_add),
      .lfd_state        (lfd_state),
      .ld_state         (ld_state),
      .full_state       (full_state),
      .laf_state        (laf_state),
      .rst_int_reg      (rst_int_reg),
      .write_enb_reg    (write_enb_reg),
      .busy             (busy)
   );

   assign outs = {detect_add, lfd_state, ld_state, full_state,
                  laf_state, rst_int_reg, write_enb_reg, busy};

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; packet_valid = 1'b0; datain = 2'b00; fifo_full = 1'b0;
      fifo_empty = 3'b000; soft_reset = 3'b000; parity_done = 1'b0;
      low_packet_valid = 1'b0;
      tick(); tick();
      chk("reset", outs, C_DEC);
      reset = 1'b0;

      // Minimal packet to port 1, then back-to-back packet from CHECK
      packet_valid = 1'b1; datain = 2'b01; fifo_empty = 3'b010;
      tick(); chk("p1_lfd", outs, C_LFD);
      tick(); chk("p1_ld", outs, C_LD);
      packet_valid = 1'b0;
      tick(); chk("p1_lp", outs, C_LP);
      packet_valid = 1'b1;
      tick(); chk("p1_chk", outs, C_CHK);
      tick(); chk("p1_dec", outs, C_DEC);
      tick(); chk("b2b_lfd", outs, C_LFD);
      packet_valid = 1'b0;
      tick(); chk("b2b_ld", outs, C_LD);
      tick(); chk("b2b_lp", outs, C_LP);
      tick(); chk("b2b_chk", outs, C_CHK);
      tick(); chk("b2b_dec", outs, C_DEC);

      // Port 2 not empty: wait five cycles, then full stall and low_packet_valid exit
      packet_valid = 1'b1; datain = 2'b10; fifo_empty = 3'b011;
      tick(); chk("wait0", outs, C_WAIT);
      datain = 2'b00;
      for (int i = 1; i < 5; i++) begin
         tick(); chk("wait_n", outs, C_WAIT);
      end
      fifo_empty = 3'b100;
      tick(); chk("wait_lfd", outs, C_LFD);
      tick(); chk("p2_ld", outs, C_LD);
      fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("full", outs, C_FULL);
      end
      fifo_full = 1'b0;
      tick(); chk("laf", outs, C_LAF);
      low_packet_valid = 1'b1;
      tick(); chk("laf_lp", outs, C_LP);
      low_packet_valid = 1'b0; packet_valid = 1'b0;
      tick(); chk("laf_chk", outs, C_CHK);
      tick(); chk("laf_dec", outs, C_DEC);

      // Stall, then LAF back to LD, stall again and parity_done exit
      packet_valid = 1'b1; datain = 2'b00; fifo_empty = 3'b001;
      tick(); chk("p0_lfd", outs, C_LFD);
      tick(); chk("p0_ld", outs, C_LD);
      fifo_full = 1'b1;
      tick(); chk("p0_full", outs, C_FULL);
      fifo_full = 1'b0;
      tick(); chk("p0_laf", outs, C_LAF);
      tick(); chk("laf_ld", outs, C_LD);
      fifo_full = 1'b1;
      tick(); chk("p0_full2", outs, C_FULL);
      fifo_full = 1'b0; parity_done = 1'b1;
      tick(); chk("p0_laf2", outs, C_LAF);
      packet_valid = 1'b0;
      tick(); chk("pd_dec", outs, C_DEC);
      parity_done = 1'b0;

      // CHECK with fifo_full goes to FULL
      packet_valid = 1'b1;
      tick(); chk("cf_lfd", outs, C_LFD);
      packet_valid = 1'b0;
      tick(); chk("cf_ld", outs, C_LD);
      tick(); chk("cf_lp", outs, C_LP);
      fifo_full = 1'b1;
      tick(); chk("cf_chk", outs, C_CHK);
      tick(); chk("cf_full", outs, C_FULL);
      fifo_full = 1'b0;
      tick(); chk("cf_laf", outs, C_LAF);
      tick(); chk("cf_ld2", outs, C_LD);
      packet_valid = 1'b0;
      tick(); chk("cf_lp2", outs, C_LP);
      tick(); chk("cf_chk2", outs, C_CHK);
      tick(); chk("cf_dec", outs, C_DEC);

      // Invalid address is dropped
      packet_valid = 1'b1; datain = 2'b11; fifo_empty = 3'b111;
      tick(); chk("inv0", outs, C_DEC);
      tick(); chk("inv1", outs, C_DEC);

      // Soft reset: unselected port ignored, selected port aborts
      datain = 2'b00;
      tick(); chk("sr_lfd", outs, C_LFD);
      tick(); chk("sr_ld", outs, C_LD);
      soft_reset = 3'b010;
      tick(); chk("sr_other", outs, C_LD);
      soft_reset = 3'b001; packet_valid = 1'b0;
      tick(); chk("sr_sel", outs, C_DEC);
      soft_reset = 3'b000;
      tick(); chk("sr_idle", outs, C_DEC);

      // Soft reset during WAIT_TILL_EMPTY; reset wins together with soft reset
      packet_valid = 1'b1; datain = 2'b10; fifo_empty = 3'b000;
      tick(); chk("srw_wait", outs, C_WAIT);
      packet_valid = 1'b0; soft_reset = 3'b100;
      tick(); chk("srw_dec", outs, C_DEC);
      soft_reset = 3'b000; packet_valid = 1'b1; datain = 2'b01; fifo_empty = 3'b010;
      tick(); chk("rs_lfd", outs, C_LFD);
      reset = 1'b1; soft_reset = 3'b010;
      tick(); chk("rs_dec", outs, C_DEC);
      reset = 1'b0; soft_reset = 3'b000; packet_valid = 1'b0;
      tick(); chk("rs_idle", outs, C_DEC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
